uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter among N_REQ byte-stream producers, such as the table printer, the matrix printer and the error/status printer. A requester holds ownership for a whole message. Ownership is granted round-robin, and a watchdog revokes a stalled owner. The block sits between the producers' `uart_tx_en/uart_tx_data/uart_tx_busy` ports and the UART TX core.

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_pick.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types, defaults and helpers for the UART TX arbiter
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 1_000_000;

    // Width of the owner idle counter; it only ever needs to reach TIMEOUT-1.
    function automatic int cnt_w(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker
// Ports:
//   elig   : eligible requesters
//   last   : index of the most recent winner
//   winner : first eligible index searching upward from last+1 with wrap
//   found  : at least one requester is eligible
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [2:0]       last,
    output logic [2:0]       winner,
    output logic             found
);

    logic [N_REQ-1:0] hi_mask;
    logic [N_REQ-1:0] cand;

    // Requesters strictly above 'last' get first pick; if none of them is
    // eligible the search wraps and the lowest eligible index wins.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hi_mask[i] = (i > int'(last));
        end
        cand   = (|(elig & hi_mask)) ? (elig & hi_mask) : elig;
        found  = |elig;
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner = 3'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin owner arbiter in front of a shared UART TX core
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   req[N_REQ]              : per-requester ownership request, held for a whole message
//   tx_en_i / tx_data_i     : per-requester byte strobe and byte (requester i: bits 8i+7:8i)
//   grant[N_REQ]            : registered one-hot ownership
//   busy_o[N_REQ]           : per-requester busy; only the owner sees the real UART busy
//   uart_tx_en/uart_tx_data : byte strobe and byte to the UART core
//   uart_tx_busy            : UART core busy
//   owner_id, active        : current owner index, valid while active (OWN state)
//   timeout_err             : one-cycle pulse when a stalled owner is revoked
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     tx_en_i,
    input  logic [8*N_REQ-1:0]   tx_data_i,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     busy_o,
    output logic                 uart_tx_en,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_tx_busy,
    output logic [2:0]           owner_id,
    output logic                 active,
    output logic                 timeout_err
);

    localparam int             CW       = cnt_w(TIMEOUT);
    localparam logic [CW-1:0]  IDLE_MAX = CW'(TIMEOUT - 1);
    localparam logic [2:0]     LAST_RST = 3'(N_REQ - 1);

    arb_state_t        state;
    logic [2:0]        last;
    logic [N_REQ-1:0]  locked;
    logic [CW-1:0]     idle_cnt;

    logic [2:0]        winner;
    logic              found;
    logic              own;
    logic              owner_en;
    logic [7:0]        owner_data;
    logic              owner_req;
    logic              release_req;
    logic              activity;
    logic              stall_trip;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .elig   (req & ~locked),
        .last   (last),
        .winner (winner),
        .found  (found)
    );

    // Select the owner's lane.
    always_comb begin
        owner_en   = 1'b0;
        owner_data = 8'h00;
        owner_req  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_id == 3'(i)) begin
                owner_en   = tx_en_i[i];
                owner_data = tx_data_i[8*i +: 8];
                owner_req  = req[i];
            end
        end
    end

    assign own          = (state == OWN);
    assign uart_tx_en   = own & owner_en;
    assign uart_tx_data = own ? owner_data : 8'h00;

    // A release in the same cycle as the watchdog limit takes priority, so
    // the trip term requires the owner to still be requesting.
    assign release_req  = own & ~owner_req;
    assign activity     = owner_en | uart_tx_busy;
    assign stall_trip   = own & owner_req & ~activity & (idle_cnt == IDLE_MAX);

    // The pulse has to line up with the cycle the counter hits its limit and
    // must be suppressed by a same-cycle release, so it is decoded directly
    // from registered state and the current owner inputs.
    assign timeout_err  = stall_trip;

    always_comb begin
        busy_o = '1;
        if (own) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (owner_id == 3'(i)) begin
                    busy_o[i] = uart_tx_busy;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            grant    <= '0;
            owner_id <= 3'd0;
            active   <= 1'b0;
            last     <= LAST_RST;
            locked   <= '0;
            idle_cnt <= '0;
        end else begin
            // A lock lasts until its requester lets go of req; grant is the
            // owner's one-hot, so a trip locks exactly the owner.
            locked <= (locked & req) | (stall_trip ? grant : '0);

            case (state)
                ARB: begin
                    if (found) begin
                        state    <= OWN;
                        owner_id <= winner;
                        grant    <= N_REQ'(1) << winner;
                        last     <= winner;
                        active   <= 1'b1;
                        idle_cnt <= '0;
                    end
                end
                OWN: begin
                    if (release_req || stall_trip) begin
                        state  <= DRAIN;
                        grant  <= '0;
                        active <= 1'b0;
                    end else if (activity) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (!uart_tx_busy) begin
                        state <= ARB;
                    end
                end
                default: begin
                    state <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  tx_en_i;
    logic [31:0] tx_data_i;
    logic [3:0]  grant;
    logic [3:0]  busy_o;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy;
    logic [2:0]  owner_id;
    logic        active;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb_q[$];

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  en;
        logic [31:0] data;
        logic        busy;
        logic [3:0]  exp_grant;
        logic        exp_to;
    } vec_t;

    vec_t tbl [8];

    uart_tx_arbiter #(
        .N_REQ   (4),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .tx_en_i      (tx_en_i),
        .tx_data_i    (tx_data_i),
        .grant        (grant),
        .busy_o       (busy_o),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .owner_id     (owner_id),
        .active       (active),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Drive one cycle of inputs on the falling edge, then check the outputs
    // produced by the state registered at the previous rising edge.
    task automatic step(input logic [3:0] r, input logic [3:0] e, input logic [31:0] d,
                        input logic b, input logic [3:0] eg, input logic eto);
        int         oi;
        logic [7:0] ob;
        logic [3:0] eb;
        @(negedge clk);
        req          = r;
        tx_en_i      = e;
        tx_data_i    = d;
        uart_tx_busy = b;
        oi = oh2idx(eg);
        ob = d[8*oi +: 8];
        if ((e & eg) != 4'b0000) sb_q.push_back(ob);
        #2;
        chk("grant", 32'(grant), 32'(eg));
        chk("active", 32'(active), 32'(eg != 4'b0000));
        if (eg != 4'b0000) chk("owner_id", 32'(owner_id), 32'(oi));
        eb = (eg == 4'b0000) ? 4'hF : (~eg | (b ? eg : 4'h0));
        chk("busy_o", 32'(busy_o), 32'(eb));
        chk("timeout_err", 32'(timeout_err), 32'(eto));
        chk("uart_tx_data", 32'(uart_tx_data), (eg != 4'b0000) ? 32'(ob) : 32'h0);
        chk("uart_tx_en", 32'(uart_tx_en), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) chk("fwd_byte", 32'(uart_tx_data), 32'(sb_q.pop_front()));
    endtask

    task automatic check_reset();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_owner_id", 32'(owner_id), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        chk("rst_uart_tx_en", 32'(uart_tx_en), 32'h0);
        chk("rst_uart_tx_data", 32'(uart_tx_data), 32'h0);
        chk("rst_busy_o", 32'(busy_o), 32'hF);
    endtask

    task automatic do_reset(input logic [3:0] en_hold, input logic [31:0] data_hold);
        @(negedge clk);
        tx_en_i   = en_hold;
        tx_data_i = data_hold;
        rst_n     = 1'b0;
        #2;
        check_reset();
        @(negedge clk);
        req          = 4'b0000;
        tx_en_i      = 4'b0000;
        tx_data_i    = 32'h0;
        uart_tx_busy = 1'b0;
        rst_n        = 1'b1;
    endtask

    initial begin
        logic [3:0]  oh;
        logic [31:0] d;

        rst_n        = 1'b0;
        req          = 4'b0000;
        tx_en_i      = 4'b0000;
        tx_data_i    = 32'h0;
        uart_tx_busy = 1'b0;

        //            req      en       data           busy  grant    to
        tbl[0] = '{4'b0100, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0};
        tbl[1] = '{4'b0100, 4'b0100, 32'h0031_0000, 1'b0, 4'b0100, 1'b0};
        tbl[2] = '{4'b0100, 4'b0000, 32'h0000_0000, 1'b1, 4'b0100, 1'b0};
        tbl[3] = '{4'b0100, 4'b0100, 32'h002A_0000, 1'b0, 4'b0100, 1'b0};
        tbl[4] = '{4'b0100, 4'b0001, 32'h0000_0055, 1'b0, 4'b0100, 1'b0};
        tbl[5] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0100, 1'b0};
        tbl[6] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0};
        tbl[7] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0};

        // Power-on reset, then single requester with busy and an intruder.
        do_reset(4'b0000, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].req, tbl[i].en, tbl[i].data, tbl[i].busy, tbl[i].exp_grant, tbl[i].exp_to);
        end

        // Fairness: all four requesting, each owner drops req for one cycle.
        do_reset(4'b0000, 32'h0);
        step(4'b1111, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            d  = 32'h0;
            d[8*(k%4) +: 8] = 8'h40 + 8'(k);
            step(4'b1111, oh, d, 1'b0, oh, 1'b0);
            step(4'b1111 & ~oh, 4'b0000, 32'h0, 1'b0, oh, 1'b0);
            step(4'b1111, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
            step(4'b1111, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        end
        step(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0010, 1'b0);
        step(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);

        // Drain: release while the UART stays busy for 20 cycles.
        step(4'b0001, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b0001, 4'b0001, 32'h0000_0077, 1'b0, 4'b0001, 1'b0);
        step(4'b0010, 4'b0000, 32'h0, 1'b1, 4'b0001, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(4'b0010, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0);
        end
        step(4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0010, 1'b0);
        step(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0010, 1'b0);
        step(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);

        // Grant and req drop on the same edge: one OWN cycle, then DRAIN.
        step(4'b0001, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0001, 1'b0);
        step(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);

        // Reset in the middle of a message owned by requester 2.
        step(4'b0100, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b0100, 4'b0100, 32'h0011_0000, 1'b0, 4'b0100, 1'b0);
        do_reset(4'b0100, 32'h0099_0000);
        step(4'b1111, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b1010, 4'b0000, 32'h0, 1'b0, 4'b0001, 1'b0);
        step(4'b1010, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b1010, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);

        // Timeout: requester 1 owns and stalls, requester 3 waits.
        for (int i = 0; i < 7; i++) begin
            step(4'b1010, 4'b0000, 32'h0, 1'b0, 4'b0010, 1'b0);
        end
        step(4'b1010, 4'b0000, 32'h0, 1'b0, 4'b0010, 1'b1);
        step(4'b1010, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b1010, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b1010, 4'b1000, 32'h5A00_0000, 1'b0, 4'b1000, 1'b0);
        step(4'b0010, 4'b0000, 32'h0, 1'b0, 4'b1000, 1'b0);
        step(4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        end
        step(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);

        // Release lands on the watchdog limit cycle: no pulse.
        for (int i = 0; i < 7; i++) begin
            step(4'b0010, 4'b0000, 32'h0, 1'b0, 4'b0010, 1'b0);
        end
        step(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0010, 1'b0);
        step(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0);

        chk("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
